hex_scan_decoder: RTL and testbench



---
 rtl/hex_scan_decoder.sv | 167 ++++++++++++++++
 tb/tb_hex_scan_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_decoder.sv
// Samples a scanned, active-low seven-segment bus, debounces each segment/strobe pair,
// decodes it to a nibble and reassembles the 8-digit hex word with per-frame status.
module hex_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [7:0]  dig_sel_n,
  output logic [31:0] hex_data,
  output logic [7:0]  digit_valid,
  output logic [7:0]  digit_err,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 1);

  logic [6:0]  seg_meta_q, seg_sync_q;
  logic [7:0]  sel_meta_q, sel_sync_q;
  logic [14:0] hold_q, hold_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic [7:0]  mask_q, mask_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;

  logic [14:0] pair;
  logic        pair_same;
  logic [7:0]  sel_act;
  logic        sel_onehot;
  logic        capture;
  logic        frame_done;
  logic [3:0]  dec_nibble;
  logic        dec_legal;

  // Both buses idle high (blank, no digit) so reset mimics a dark display.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_meta_q <= '1;
      seg_sync_q <= '1;
      sel_meta_q <= '1;
      sel_sync_q <= '1;
    end else begin
      seg_meta_q <= seg_n;
      seg_sync_q <= seg_meta_q;
      sel_meta_q <= dig_sel_n;
      sel_sync_q <= sel_meta_q;
    end
  end

  assign pair       = {seg_sync_q, sel_sync_q};
  assign pair_same  = (pair == hold_q);
  assign sel_act    = ~sel_sync_q;
  assign sel_onehot = (sel_act != 8'd0) && ((sel_act & (sel_act - 8'd1)) == 8'd0);
  assign capture    = pair_same && (cnt_q == CNT_CAP) && armed_q && sel_onehot;
  assign frame_done = &mask_q;

  always_comb begin
    dec_nibble = 4'h0;
    dec_legal  = 1'b1;
    case (seg_sync_q)
      7'h40: dec_nibble = 4'h0;
      7'h79: dec_nibble = 4'h1;
      7'h24: dec_nibble = 4'h2;
      7'h30: dec_nibble = 4'h3;
      7'h19: dec_nibble = 4'h4;
      7'h12: dec_nibble = 4'h5;
      7'h02: dec_nibble = 4'h6;
      7'h78: dec_nibble = 4'h7;
      7'h00: dec_nibble = 4'h8;
      7'h10: dec_nibble = 4'h9;
      7'h08: dec_nibble = 4'hA;
      7'h03: dec_nibble = 4'hB;
      7'h46: dec_nibble = 4'hC;
      7'h21: dec_nibble = 4'hD;
      7'h06: dec_nibble = 4'hE;
      7'h0E: dec_nibble = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end

  // Any change of the pair restarts the dwell and re-arms a single capture.
  always_comb begin
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (!pair_same) begin
      hold_d  = pair;
      cnt_d   = 8'd1;
      armed_d = 1'b1;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 8'd1;
      end
      if (capture) begin
        armed_d = 1'b0;
      end
    end
  end

  always_comb begin
    mask_d        = frame_done ? 8'd0 : mask_q;
    frame_valid_d = frame_done;
    frame_err_d   = frame_done ? (|digit_err) : frame_err_q;
    if (capture) begin
      mask_d = mask_d | sel_act;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q        <= '1;
      cnt_q         <= 8'd0;
      armed_q       <= 1'b1;
      mask_q        <= 8'd0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      mask_q        <= mask_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      logic [3:0] nib_q;
      logic       val_q;
      logic       err_q;
      logic       hit;

      assign hit = capture & sel_act[gi];

      // An illegal pattern keeps the last good nibble but flags the digit.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          nib_q <= 4'h0;
          val_q <= 1'b0;
          err_q <= 1'b0;
        end else if (hit) begin
          if (dec_legal) begin
            nib_q <= dec_nibble;
            val_q <= 1'b1;
            err_q <= 1'b0;
          end else begin
            val_q <= 1'b0;
            err_q <= 1'b1;
          end
        end
      end

      assign hex_data[4*gi +: 4] = nib_q;
      assign digit_valid[gi]     = val_q;
      assign digit_err[gi]       = err_q;
    end
  endgenerate

endmodule

// File: tb/tb_hex_scan_decoder.sv
// Directed-vector bench for hex_scan_decoder: scans whole and partial frames and checks
// latency, glitch rejection, illegal patterns, multi-strobe rejection and reset.
module tb_hex_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [7:0]  dig_sel_n;
  logic [31:0] hex_data;
  logic [7:0]  digit_valid;
  logic [7:0]  digit_err;
  logic        frame_valid;
  logic        frame_err;

  int   errors = 0;
  int   checks = 0;
  int   pulse_cnt = 0;
  logic last_ferr = 1'b0;

  hex_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_sel_n   (dig_sel_n),
    .hex_data    (hex_data),
    .digit_valid (digit_valid),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Counts cycles with frame_valid high; a stuck or stretched pulse shows up as >1.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      last_ferr <= frame_err;
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] r;
    r = 7'h7F;
    case (n)
      4'h0: r = 7'h40; 4'h1: r = 7'h79; 4'h2: r = 7'h24; 4'h3: r = 7'h30;
      4'h4: r = 7'h19; 4'h5: r = 7'h12; 4'h6: r = 7'h02; 4'h7: r = 7'h78;
      4'h8: r = 7'h00; 4'h9: r = 7'h10; 4'hA: r = 7'h08; 4'hB: r = 7'h03;
      4'hC: r = 7'h46; 4'hD: r = 7'h21; 4'hE: r = 7'h06; 4'hF: r = 7'h0E;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan_digit(input int d, input logic [6:0] pat, input int dwell);
    seg_n     = pat;
    dig_sel_n = ~(8'(1) << d);
    step(dwell);
    seg_n     = 7'h7F;
    dig_sel_n = 8'hFF;
    step(2);
  endtask

  task automatic scan_word(input logic [31:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      scan_digit(i, enc(w[4*i +: 4]), 8);
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    seg_n     = 7'h7F;
    dig_sel_n = 8'hFF;
    step(3);
    checks++; if (hex_data !== 32'h0) begin errors++; $display("FAIL reset_hex: got %h expected %h", hex_data, 32'h0); end
    checks++; if (digit_valid !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h expected %h", digit_valid, 8'h00); end
    checks++; if (digit_err !== 8'h00) begin errors++; $display("FAIL reset_err: got %h expected %h", digit_err, 8'h00); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fvalid: got %b expected 0", frame_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    rst_n = 1'b1;
    step(2);
    $display("test_reset done");
  endtask

  task automatic test_full_scan;
    int p0;
    p0 = pulse_cnt;
    seg_n     = enc(4'hD);
    dig_sel_n = 8'hFE;
    step(S + 1);
    checks++; if (digit_valid[0] !== 1'b0) begin errors++; $display("FAIL latency_early: got valid0=%b expected 0", digit_valid[0]); end
    step(1);
    checks++; if (digit_valid[0] !== 1'b1 || hex_data[3:0] !== 4'hD) begin
      errors++; $display("FAIL latency_capture: got valid0=%b nib0=%h expected 1/d", digit_valid[0], hex_data[3:0]);
    end
    step(8 - S - 2);
    seg_n     = 7'h7F;
    dig_sel_n = 8'hFF;
    step(2);
    scan_word(32'h1234ABCD, 1, 7);
    checks++; if (hex_data !== 32'h1234ABCD) begin errors++; $display("FAIL full_hex: got %h expected %h", hex_data, 32'h1234ABCD); end
    checks++; if (digit_valid !== 8'hFF) begin errors++; $display("FAIL full_valid: got %h expected ff", digit_valid); end
    checks++; if (digit_err !== 8'h00) begin errors++; $display("FAIL full_err: got %h expected 00", digit_err); end
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL full_pulses: got %0d expected 1", pulse_cnt - p0); end
    checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL full_ferr: got %b expected 0", last_ferr); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL full_pulse_len: got %b expected 0", frame_valid); end
    $display("test_full_scan done hex=%h", hex_data);
  endtask

  task automatic test_glitch;
    int         changes;
    logic       saw_zero;
    logic [3:0] prev;
    changes  = 0;
    saw_zero = 1'b0;
    prev     = hex_data[15:12];
    dig_sel_n = 8'hF7;
    for (int i = 0; i < S - 1 + 8; i++) begin
      seg_n = (i < S - 1) ? 7'h40 : 7'h79;
      step(1);
      if (hex_data[15:12] !== prev) begin
        changes++;
        prev = hex_data[15:12];
      end
      if (hex_data[15:12] === 4'h0) saw_zero = 1'b1;
    end
    seg_n     = 7'h7F;
    dig_sel_n = 8'hFF;
    step(2);
    checks++; if (saw_zero !== 1'b0) begin errors++; $display("FAIL glitch_zero: got saw_zero=%b expected 0", saw_zero); end
    checks++; if (changes !== 1) begin errors++; $display("FAIL glitch_captures: got %0d expected 1", changes); end
    checks++; if (hex_data !== 32'h12341BCD) begin errors++; $display("FAIL glitch_hex: got %h expected %h", hex_data, 32'h12341BCD); end
    checks++; if (digit_valid !== 8'hFF) begin errors++; $display("FAIL glitch_valid: got %h expected ff", digit_valid); end
    $display("test_glitch done hex=%h", hex_data);
  endtask

  task automatic test_blank_digit;
    int          p0;
    logic [31:0] w;
    p0 = pulse_cnt;
    w  = 32'h89ABCDEF;
    for (int i = 0; i < 8; i++) begin
      scan_digit(i, (i == 5) ? 7'h7F : enc(w[4*i +: 4]), 8);
    end
    checks++; if (hex_data !== 32'h893BCDEF) begin errors++; $display("FAIL blank_hex: got %h expected %h", hex_data, 32'h893BCDEF); end
    checks++; if (digit_valid !== 8'hDF) begin errors++; $display("FAIL blank_valid: got %h expected df", digit_valid); end
    checks++; if (digit_err !== 8'h20) begin errors++; $display("FAIL blank_err: got %h expected 20", digit_err); end
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL blank_pulses: got %0d expected 1", pulse_cnt - p0); end
    checks++; if (last_ferr !== 1'b1) begin errors++; $display("FAIL blank_ferr_pulse: got %b expected 1", last_ferr); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL blank_ferr_hold: got %b expected 1", frame_err); end
    $display("test_blank_digit done hex=%h", hex_data);
  endtask

  task automatic test_multi_low;
    int p0;
    p0 = pulse_cnt;
    seg_n     = 7'h40;
    dig_sel_n = 8'hFC;
    step(20);
    seg_n     = 7'h7F;
    dig_sel_n = 8'hFF;
    step(2);
    checks++; if (hex_data !== 32'h893BCDEF) begin errors++; $display("FAIL multi_hex: got %h expected %h", hex_data, 32'h893BCDEF); end
    checks++; if (digit_valid !== 8'hDF) begin errors++; $display("FAIL multi_valid: got %h expected df", digit_valid); end
    checks++; if (digit_err !== 8'h20) begin errors++; $display("FAIL multi_err: got %h expected 20", digit_err); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL multi_ferr: got %b expected 1", frame_err); end
    // Digits 0/1 must still be missing from the frame, so 2..7 alone cannot finish it.
    scan_word(32'h76507650, 2, 7);
    checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL multi_mask: got %0d pulses expected 0", pulse_cnt - p0); end
    checks++; if (hex_data !== 32'h765076EF) begin errors++; $display("FAIL multi_scan_hex: got %h expected %h", hex_data, 32'h765076EF); end
    $display("test_multi_low done hex=%h", hex_data);
  endtask

  task automatic test_hold_100;
    int          p0;
    int          changes;
    logic [47:0] prev;
    scan_digit(0, enc(4'h0), 8);
    p0      = pulse_cnt;
    changes = 0;
    prev    = {hex_data, digit_valid, digit_err};
    seg_n     = enc(4'h5);
    dig_sel_n = 8'hFD;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if ({hex_data, digit_valid, digit_err} !== prev) begin
        changes++;
        prev = {hex_data, digit_valid, digit_err};
      end
    end
    seg_n     = 7'h7F;
    dig_sel_n = 8'hFF;
    step(2);
    checks++; if (changes !== 1) begin errors++; $display("FAIL hold_captures: got %0d expected 1", changes); end
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL hold_pulses: got %0d expected 1", pulse_cnt - p0); end
    checks++; if (hex_data !== 32'h76507650) begin errors++; $display("FAIL hold_hex: got %h expected %h", hex_data, 32'h76507650); end
    checks++; if (digit_valid !== 8'hFF) begin errors++; $display("FAIL hold_valid: got %h expected ff", digit_valid); end
    checks++; if (digit_err !== 8'h00) begin errors++; $display("FAIL hold_err: got %h expected 00", digit_err); end
    checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL hold_ferr: got %b expected 0", last_ferr); end
    $display("test_hold_100 done hex=%h", hex_data);
  endtask

  task automatic test_reset_mid_frame;
    int p0;
    scan_word(32'h99999999, 0, 3);
    rst_n = 1'b0;
    step(1);
    checks++; if (hex_data !== 32'h0) begin errors++; $display("FAIL mid_rst_hex: got %h expected 0", hex_data); end
    checks++; if (digit_valid !== 8'h00) begin errors++; $display("FAIL mid_rst_valid: got %h expected 00", digit_valid); end
    checks++; if (digit_err !== 8'h00) begin errors++; $display("FAIL mid_rst_err: got %h expected 00", digit_err); end
    checks++; if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL mid_rst_frame: got fv=%b fe=%b expected 0/0", frame_valid, frame_err);
    end
    rst_n = 1'b1;
    step(2);
    p0 = pulse_cnt;
    scan_word(32'hCAFE1234, 4, 7);
    checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL mid_partial_pulses: got %0d expected 0", pulse_cnt - p0); end
    checks++; if (digit_valid !== 8'hF0) begin errors++; $display("FAIL mid_partial_valid: got %h expected f0", digit_valid); end
    scan_word(32'hCAFE1234, 0, 3);
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL mid_full_pulses: got %0d expected 1", pulse_cnt - p0); end
    checks++; if (hex_data !== 32'hCAFE1234) begin errors++; $display("FAIL mid_full_hex: got %h expected %h", hex_data, 32'hCAFE1234); end
    checks++; if (digit_valid !== 8'hFF || digit_err !== 8'h00) begin
      errors++; $display("FAIL mid_full_status: got valid=%h err=%h expected ff/00", digit_valid, digit_err);
    end
    $display("test_reset_mid_frame done hex=%h", hex_data);
  endtask

  initial begin
    rst_n     = 1'b0;
    seg_n     = 7'h7F;
    dig_sel_n = 8'hFF;
    @(posedge clk);
    #1;
    test_reset;
    test_full_scan;
    test_glitch;
    test_blank_digit;
    test_multi_low;
    test_hold_100;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
